// File: rtl/dcache_req_arbiter_pkg.sv
// rtl/dcache_req_arbiter_pkg.sv - shared encodings for the dcache request arbiter
//
// Purpose: owner and lock encodings, the owner-FIFO entry layout and the
// access-size codes shared with the dcache.
// Ports: none (package).

package dcache_req_arbiter_pkg;

  // Which pipe issued an accepted request.
  localparam logic OWN_P1 = 1'b0;
  localparam logic OWN_P2 = 1'b1;

  // Pipe holding the request port while the dcache withholds addr_ok.
  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_P1   = 2'd1,
    LOCK_P2   = 2'd2
  } lock_e;

  // Access size codes, identical to the dcache's.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic owner;
    logic discard;
  } own_entry_t;

endpackage

// File: rtl/arb_owner_fifo.sv
// rtl/arb_owner_fifo.sv - in-order owner FIFO with broadcast discard
//
// Purpose: remembers which pipe issued each accepted dcache request so the
// in-order responses can be routed back; a flush marks every held entry as
// discard so its response is swallowed but still popped.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_owner    enqueue {push_owner, discard=0}
//   pop                 dequeue head (caller guarantees count != 0)
//   discard_all         set discard on every held entry
//   head_owner/discard  head entry fields
//   full, count         occupancy

import dcache_req_arbiter_pkg::*;

module arb_owner_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_owner,
  input  logic             pop,
  input  logic             discard_all,
  output logic             head_owner,
  output logic             head_discard,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  own_entry_t       entries_q [DEPTH];
  own_entry_t       entries_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;

    // Discard is set on every slot, not only the valid ones: an empty slot
    // is always rewritten with discard = 0 when it is next pushed.
    if (discard_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].discard = 1'b1;
      end
    end

    if (push) begin
      entries_d[wr_ptr_q] = '{owner: push_owner, discard: 1'b0};
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '{owner: OWN_P1, discard: 1'b0};
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  assign head_owner   = entries_q[rd_ptr_q].owner;
  assign head_discard = entries_q[rd_ptr_q].discard;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign count        = count_q;

endmodule

// File: rtl/dcache_req_arbiter.sv
// rtl/dcache_req_arbiter.sv - two-pipe arbiter for the single dcache request port
//
// Purpose: grants the dcache port to pipe 1 (older) or pipe 2 (younger),
// holds the grant until addr_ok, and routes in-order data_ok/rdata back to
// the issuing pipe, dropping responses of flushed requests.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   flush                             exception/eret flush pulse
//   req_x/wr_x/size_x/wstrb_x/addr_x/wdata_x   pipe x request
//   addr_ok_x, data_ok_x              per-pipe handshake / response
//   rdata_out                         shared load data
//   dcache_*                          dcache request/response port
//   busy                              any request outstanding

import dcache_req_arbiter_pkg::*;

module dcache_req_arbiter #(
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_1,
  input  logic        req_2,
  input  logic        wr_1,
  input  logic        wr_2,
  input  logic [1:0]  size_1,
  input  logic [1:0]  size_2,
  input  logic [3:0]  wstrb_1,
  input  logic [3:0]  wstrb_2,
  input  logic [31:0] addr_1,
  input  logic [31:0] addr_2,
  input  logic [31:0] wdata_1,
  input  logic [31:0] wdata_2,
  output logic        addr_ok_1,
  output logic        addr_ok_2,
  output logic        data_ok_1,
  output logic        data_ok_2,
  output logic [31:0] rdata_out,
  output logic        dcache_req,
  output logic        dcache_wr,
  output logic [1:0]  dcache_size,
  output logic [3:0]  dcache_wstrb,
  output logic [31:0] dcache_addr,
  output logic [31:0] dcache_wdata,
  input  logic        dcache_addr_ok,
  input  logic        dcache_data_ok,
  input  logic [31:0] dcache_rdata,
  output logic        busy
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  lock_e            lock_q, lock_d;
  logic             sel_p2;
  logic             req_sel;
  logic             handshake;
  logic             pop;
  logic             fifo_full;
  logic             head_owner;
  logic             head_discard;
  logic [CNT_W-1:0] count;

  // A held lock wins outright; otherwise the older slot has priority.
  always_comb begin
    sel_p2  = (lock_q == LOCK_P2) ||
              ((lock_q == LOCK_NONE) && !req_1 && req_2);
    req_sel = sel_p2 ? req_2 : req_1;
  end

  always_comb begin
    dcache_req   = req_sel && !fifo_full && !flush;
    dcache_wr    = 1'b0;
    dcache_size  = 2'd0;
    dcache_wstrb = 4'd0;
    dcache_addr  = 32'd0;
    dcache_wdata = 32'd0;
    if (req_sel) begin
      dcache_wr    = sel_p2 ? wr_2    : wr_1;
      dcache_size  = sel_p2 ? size_2  : size_1;
      dcache_wstrb = sel_p2 ? wstrb_2 : wstrb_1;
      dcache_addr  = sel_p2 ? addr_2  : addr_1;
      dcache_wdata = sel_p2 ? wdata_2 : wdata_1;
    end
  end

  assign handshake = dcache_req && dcache_addr_ok;
  assign addr_ok_1 = handshake && !sel_p2;
  assign addr_ok_2 = handshake && sel_p2;

  always_comb begin
    lock_d = lock_q;
    if (flush || handshake) begin
      lock_d = LOCK_NONE;
    end else if (dcache_req) begin
      lock_d = sel_p2 ? LOCK_P2 : LOCK_P1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= LOCK_NONE;
    end else begin
      lock_q <= lock_d;
    end
  end

  // A data_ok with nothing outstanding is a dcache protocol error; ignore it.
  assign pop = dcache_data_ok && (count != '0);

  arb_owner_fifo #(
    .DEPTH (OUT_DEPTH),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (handshake),
    .push_owner   (sel_p2 ? OWN_P2 : OWN_P1),
    .pop          (pop),
    .discard_all  (flush),
    .head_owner   (head_owner),
    .head_discard (head_discard),
    .full         (fifo_full),
    .count        (count)
  );

  // The flush term covers a response landing in the flush cycle itself,
  // before the discard bits have been written.
  assign data_ok_1 = pop && !head_discard && !flush && (head_owner == OWN_P1);
  assign data_ok_2 = pop && !head_discard && !flush && (head_owner == OWN_P2);
  assign rdata_out = dcache_rdata;
  assign busy      = (count != '0);

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// tb/tb_dcache_req_arbiter.sv - directed self-checking bench for dcache_req_arbiter

module tb_dcache_req_arbiter;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        req_1, req_2, wr_1, wr_2;
  logic [1:0]  size_1, size_2;
  logic [3:0]  wstrb_1, wstrb_2;
  logic [31:0] addr_1, addr_2, wdata_1, wdata_2;
  logic        addr_ok_1, addr_ok_2, data_ok_1, data_ok_2;
  logic [31:0] rdata_out;
  logic        dcache_req, dcache_wr;
  logic [1:0]  dcache_size;
  logic [3:0]  dcache_wstrb;
  logic [31:0] dcache_addr, dcache_wdata;
  logic        dcache_addr_ok, dcache_data_ok;
  logic [31:0] dcache_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_req_arbiter #(.OUT_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_1(req_1), .req_2(req_2), .wr_1(wr_1), .wr_2(wr_2),
    .size_1(size_1), .size_2(size_2), .wstrb_1(wstrb_1), .wstrb_2(wstrb_2),
    .addr_1(addr_1), .addr_2(addr_2), .wdata_1(wdata_1), .wdata_2(wdata_2),
    .addr_ok_1(addr_ok_1), .addr_ok_2(addr_ok_2),
    .data_ok_1(data_ok_1), .data_ok_2(data_ok_2), .rdata_out(rdata_out),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_size(dcache_size),
    .dcache_wstrb(dcache_wstrb), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_addr_ok(dcache_addr_ok), .dcache_data_ok(dcache_data_ok),
    .dcache_rdata(dcache_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed and
  // given 1 time unit to settle before outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    req_1 = 1'b0; req_2 = 1'b0; wr_1 = 1'b0; wr_2 = 1'b0;
    size_1 = 2'd2; size_2 = 2'd2; wstrb_1 = 4'h0; wstrb_2 = 4'h0;
    addr_1 = 32'hFFFF_0000; addr_2 = 32'hEEEE_0000;
    wdata_1 = 32'h0; wdata_2 = 32'h0;
    dcache_addr_ok = 1'b0; dcache_data_ok = 1'b0; dcache_rdata = 32'hA5A5_A5A5;
    tick(); tick();
    reset = 1'b0;
    settle();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_dreq", dcache_req, 0);
    chk("rst_aok1", addr_ok_1, 0);
    chk("rst_aok2", addr_ok_2, 0);
    chk("rst_dok1", data_ok_1, 0);
    chk("rst_dok2", data_ok_2, 0);
    chk("rst_rdata", rdata_out, 32'hA5A5_A5A5);
    chk("rst_addr_unsel", dcache_addr, 0);
    tick();

    // Simultaneous requests: pipe 1 first, pipe 2 next cycle
    req_1 = 1; addr_1 = 32'h0000_1000; wr_1 = 0; wstrb_1 = 4'h0;
    req_2 = 1; addr_2 = 32'h0000_2000; wr_2 = 1; wstrb_2 = 4'hF; wdata_2 = 32'hCAFE_F00D;
    dcache_addr_ok = 1;
    settle();
    chk("both_c0_dreq", dcache_req, 1);
    chk("both_c0_addr", dcache_addr, 32'h1000);
    chk("both_c0_aok1", addr_ok_1, 1);
    chk("both_c0_aok2", addr_ok_2, 0);
    chk("both_c0_wr", dcache_wr, 0);
    chk("both_c0_size", dcache_size, 2);
    tick();
    req_1 = 0;
    settle();
    chk("both_c1_addr", dcache_addr, 32'h2000);
    chk("both_c1_aok2", addr_ok_2, 1);
    chk("both_c1_aok1", addr_ok_1, 0);
    chk("both_c1_wr", dcache_wr, 1);
    chk("both_c1_wstrb", dcache_wstrb, 4'hF);
    chk("both_c1_wdata", dcache_wdata, 32'hCAFE_F00D);
    tick();

    // Two outstanding (full): new req_1 stalls, also in the data_ok cycle
    req_2 = 0; req_1 = 1; addr_1 = 32'h0000_3000; wr_1 = 0;
    settle();
    chk("full_busy", busy, 1);
    chk("full_dreq", dcache_req, 0);
    chk("full_aok1", addr_ok_1, 0);
    tick();
    dcache_data_ok = 1; dcache_rdata = 32'hDEAD_BEEF;
    settle();
    chk("full_dok_dreq", dcache_req, 0);
    chk("full_dok_aok1", addr_ok_1, 0);
    chk("resp0_dok1", data_ok_1, 1);
    chk("resp0_dok2", data_ok_2, 0);
    chk("resp0_rdata", rdata_out, 32'hDEAD_BEEF);
    tick();
    // Second response routes to pipe 2; pipe 1 accepted in same cycle
    dcache_rdata = 32'h1234_5678;
    settle();
    chk("resp1_dok2", data_ok_2, 1);
    chk("resp1_dok1", data_ok_1, 0);
    chk("resp1_rdata", rdata_out, 32'h1234_5678);
    chk("after_full_dreq", dcache_req, 1);
    chk("after_full_aok1", addr_ok_1, 1);
    tick();
    req_1 = 0; dcache_data_ok = 0;
    settle();
    chk("pushpop_busy", busy, 1);
    tick();
    dcache_data_ok = 1; dcache_rdata = 32'h1111_2222;
    settle();
    chk("resp2_dok1", data_ok_1, 1);
    chk("resp2_dok2", data_ok_2, 0);
    tick();
    settle();
    chk("drained_busy", busy, 0);
    // Stray data_ok with nothing outstanding is ignored
    chk("stray_dok1", data_ok_1, 0);
    chk("stray_dok2", data_ok_2, 0);
    tick();
    dcache_data_ok = 0;
    settle();
    chk("stray_busy", busy, 0);
    tick();

    // Lock: pipe 2 waits for addr_ok while pipe 1 rises
    dcache_addr_ok = 0; req_2 = 1; addr_2 = 32'h0000_2000; wr_2 = 0; wstrb_2 = 4'h0;
    settle();
    chk("lock_c0_dreq", dcache_req, 1);
    chk("lock_c0_addr", dcache_addr, 32'h2000);
    chk("lock_c0_aok2", addr_ok_2, 0);
    tick();
    req_1 = 1; addr_1 = 32'h0000_3000;
    settle();
    chk("lock_c1_addr", dcache_addr, 32'h2000);
    chk("lock_c1_aok1", addr_ok_1, 0);
    tick();
    settle();
    chk("lock_c2_addr", dcache_addr, 32'h2000);
    tick();
    dcache_addr_ok = 1;
    settle();
    chk("lock_c3_aok2", addr_ok_2, 1);
    chk("lock_c3_aok1", addr_ok_1, 0);
    chk("lock_c3_addr", dcache_addr, 32'h2000);
    tick();
    req_2 = 0;
    settle();
    chk("lock_c4_addr", dcache_addr, 32'h3000);
    chk("lock_c4_aok1", addr_ok_1, 1);
    tick();

    // Flush with two outstanding; a data_ok in the flush cycle is dropped
    req_1 = 1; addr_1 = 32'h0000_4000; flush = 1; dcache_data_ok = 1; dcache_rdata = 32'h5555_0000;
    settle();
    chk("flush_dreq", dcache_req, 0);
    chk("flush_aok1", addr_ok_1, 0);
    chk("flush_c_dok1", data_ok_1, 0);
    chk("flush_c_dok2", data_ok_2, 0);
    tick();
    flush = 0;
    settle();
    chk("post_flush_dok1", data_ok_1, 0);
    chk("post_flush_dok2", data_ok_2, 0);
    chk("post_flush_dreq", dcache_req, 1);
    chk("post_flush_aok1", addr_ok_1, 1);
    tick();
    req_1 = 0; dcache_rdata = 32'h5555_AAAA;
    settle();
    chk("new_after_flush_dok1", data_ok_1, 1);
    chk("new_after_flush_rdata", rdata_out, 32'h5555_AAAA);
    tick();
    dcache_data_ok = 0;
    settle();
    chk("flush_drained_busy", busy, 0);
    tick();

    // Reset while lock = P1 and one request outstanding
    req_1 = 1; addr_1 = 32'h0000_6000;
    tick();
    dcache_addr_ok = 0;
    tick();
    settle();
    chk("pre_rst_busy", busy, 1);
    reset = 1;
    tick();
    reset = 0; req_1 = 0; req_2 = 1; addr_2 = 32'h0000_7000;
    settle();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dreq", dcache_req, 1);
    chk("mid_rst_addr", dcache_addr, 32'h7000);
    chk("mid_rst_dok1", data_ok_1, 0);
    tick();
    req_2 = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
